fx_chan_sched: RTL and testbench

Controller that sequences one shared external effect core across the left and right audio channels. When a stereo sample pair arrives on the `VALID` strobe, the block captures it and issues two serial requests to the core: left first, then right. It collects both results and presents them as a registered stereo pair with a one-cycle `out_valid` pulse. It sits between the codec sample interface and the audio output path. It replaces direct talkthrough, which is still available via `bypass`.

---
 rtl/fx_pkg.sv | 17 +
 rtl/fx_watchdog.sv | 42 ++++
 rtl/fx_chan_sched.sv | 194 +++++++++++++++++++
 tb/tb_fx_chan_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared types and defaults for the stereo effect-core channel scheduler.
package fx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_L = 2'd1,
        REQ_R = 2'd2
    } fx_state_e;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } fx_chan_e;

    localparam int FX_DATA_W = 16;

endpackage

// File: rtl/fx_watchdog.sv
// Request watchdog: counts cycles without ack since the last start and flags
// expiry when the count reaches TIMEOUT. Built only with FX_WATCHDOG_EN.
module fx_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on entry, hold on ack, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (!ack && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/fx_chan_sched.sv
// Sequences one shared effect core over the left then right channel of each
// captured stereo pair. Optional request watchdog: define FX_WATCHDOG_EN.
module fx_chan_sched
    import fx_pkg::*;
#(
    parameter int DATA_W  = FX_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              VALID,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              bypass,
    input  logic              clr_err,
    output logic              core_req,
    output logic              core_chan,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_ack,
    input  logic [DATA_W-1:0] core_dout,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              out_valid,
    output logic              overrun,
    output logic              timeout_err
);

    fx_state_e         state_q, state_d;
    logic [DATA_W-1:0] cap_l_q, cap_l_d;
    logic [DATA_W-1:0] cap_r_q, cap_r_d;
    logic [DATA_W-1:0] res_l_q, res_l_d;
    logic [DATA_W-1:0] left_out_q, left_out_d;
    logic [DATA_W-1:0] right_out_q, right_out_d;
    logic [DATA_W-1:0] core_din_q, core_din_d;
    fx_chan_e          core_chan_q, core_chan_d;
    logic              core_req_q, core_req_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ovr_evt_s;
    logic              to_evt_s;
    logic              wd_expired_s;

`ifdef FX_WATCHDOG_EN
    logic wd_start_s;

    // Any transition into a request state restarts the wait count.
    assign wd_start_s = (state_d != state_q) && (state_d != IDLE);

    fx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wd_start_s),
        .ack     (core_ack),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // Next-state, capture and output-register logic; request outputs are
    // computed from the next state so they are registered yet aligned with it.
    always_comb begin
        state_d     = state_q;
        cap_l_d     = cap_l_q;
        cap_r_d     = cap_r_q;
        res_l_d     = res_l_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        core_din_d  = core_din_q;
        core_chan_d = CH_L;
        core_req_d  = 1'b0;
        out_valid_d = 1'b0;
        ovr_evt_s   = 1'b0;
        to_evt_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (VALID) begin
                    cap_l_d = left_in;
                    cap_r_d = right_in;
                    if (bypass) begin
                        left_out_d  = left_in;
                        right_out_d = right_in;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = REQ_L;
                        core_req_d  = 1'b1;
                        core_chan_d = CH_L;
                        core_din_d  = left_in;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ_L: begin
                ovr_evt_s   = VALID;
                core_req_d  = 1'b1;
                core_chan_d = CH_L;
                core_din_d  = cap_l_q;
                // A real ack beats a same-cycle watchdog expiry.
                if (core_ack || wd_expired_s) begin
                    res_l_d     = core_ack ? core_dout : cap_l_q;
                    to_evt_s    = !core_ack;
                    state_d     = REQ_R;
                    core_chan_d = CH_R;
                    core_din_d  = cap_r_q;
                end else begin
                    state_d = REQ_L;
                end
            end
            REQ_R: begin
                ovr_evt_s   = VALID;
                core_req_d  = 1'b1;
                core_chan_d = CH_R;
                core_din_d  = cap_r_q;
                if (core_ack || wd_expired_s) begin
                    left_out_d  = res_l_q;
                    right_out_d = core_ack ? core_dout : cap_r_q;
                    to_evt_s    = !core_ack;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    core_req_d  = 1'b0;
                    core_chan_d = CH_L;
                end else begin
                    state_d = REQ_R;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sticky flags: a new error event wins over a same-cycle clear.
        if (ovr_evt_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (to_evt_s) begin
            timeout_err_d = 1'b1;
        end else if (clr_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cap_l_q       <= {DATA_W{1'b0}};
            cap_r_q       <= {DATA_W{1'b0}};
            res_l_q       <= {DATA_W{1'b0}};
            left_out_q    <= {DATA_W{1'b0}};
            right_out_q   <= {DATA_W{1'b0}};
            core_din_q    <= {DATA_W{1'b0}};
            core_chan_q   <= CH_L;
            core_req_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_l_q       <= cap_l_d;
            cap_r_q       <= cap_r_d;
            res_l_q       <= res_l_d;
            left_out_q    <= left_out_d;
            right_out_q   <= right_out_d;
            core_din_q    <= core_din_d;
            core_chan_q   <= core_chan_d;
            core_req_q    <= core_req_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign core_req    = core_req_q;
    assign core_chan   = core_chan_q;
    assign core_din    = core_din_q;
    assign left_out    = left_out_q;
    assign right_out   = right_out_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fx_chan_sched.sv
// Directed self-checking bench for fx_chan_sched; the watchdog scenario runs
// only when FX_WATCHDOG_EN is defined (DUT built with TIMEOUT=4).
module tb_fx_chan_sched;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] left_in = '0;
    logic [DW-1:0] right_in = '0;
    logic          bypass = 1'b0;
    logic          clr_err = 1'b0;
    logic          core_req;
    logic          core_chan;
    logic [DW-1:0] core_din;
    logic          core_ack = 1'b0;
    logic [DW-1:0] core_dout = '0;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          out_valid;
    logic          overrun;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    fx_chan_sched #(
        .DATA_W  (DW),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .VALID       (valid),
        .left_in     (left_in),
        .right_in    (right_in),
        .bypass      (bypass),
        .clr_err     (clr_err),
        .core_req    (core_req),
        .core_chan   (core_chan),
        .core_din    (core_din),
        .core_ack    (core_ack),
        .core_dout   (core_dout),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_time_limit observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset and idle
        tick();
        chk("rst_req", 32'(core_req), 32'd0);
        chk("rst_left", 32'(left_out), 32'd0);
        chk("rst_right", 32'(right_out), 32'd0);
        chk("rst_oval", 32'(out_valid), 32'd0);
        chk("rst_din", 32'(core_din), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_req", 32'(core_req), 32'd0);
        chk("idle_oval", 32'(out_valid), 32'd0);

        // Normal pair, zero-wait core returning din ^ 0xFFFF
        valid = 1'b1; left_in = 16'h1234; right_in = 16'hABCD; bypass = 1'b0;
        tick();
        valid = 1'b0;
        chk("n_req_l", 32'(core_req), 32'd1);
        chk("n_chan_l", 32'(core_chan), 32'd0);
        chk("n_din_l", 32'(core_din), 32'h1234);
        core_ack = 1'b1; core_dout = 16'hEDCB;
        tick();
        chk("n_req_r", 32'(core_req), 32'd1);
        chk("n_chan_r", 32'(core_chan), 32'd1);
        chk("n_din_r", 32'(core_din), 32'hABCD);
        chk("n_oval_early", 32'(out_valid), 32'd0);
        core_dout = 16'h5432;
        tick();
        core_ack = 1'b0;
        chk("n_oval", 32'(out_valid), 32'd1);
        chk("n_left", 32'(left_out), 32'hEDCB);
        chk("n_right", 32'(right_out), 32'h5432);
        chk("n_req_done", 32'(core_req), 32'd0);
        chk("n_din_hold", 32'(core_din), 32'hABCD);
        tick();
        chk("n_oval_pulse", 32'(out_valid), 32'd0);
        chk("n_left_hold", 32'(left_out), 32'hEDCB);

        // Bypass talkthrough
        valid = 1'b1; left_in = 16'h7FFF; right_in = 16'h8000; bypass = 1'b1;
        tick();
        valid = 1'b0; bypass = 1'b0;
        chk("b_oval", 32'(out_valid), 32'd1);
        chk("b_left", 32'(left_out), 32'h7FFF);
        chk("b_right", 32'(right_out), 32'h8000);
        chk("b_req", 32'(core_req), 32'd0);
        tick();
        chk("b_req2", 32'(core_req), 32'd0);
        chk("b_oval2", 32'(out_valid), 32'd0);

        // Overrun: second VALID during delayed REQ_L
        valid = 1'b1; left_in = 16'h0101; right_in = 16'h0202;
        tick();
        left_in = 16'h5555; right_in = 16'h6666;
        chk("o_req_l", 32'(core_req), 32'd1);
        tick();
        valid = 1'b0;
        chk("o_flag", 32'(overrun), 32'd1);
        chk("o_din_l", 32'(core_din), 32'h0101);
        for (int i = 0; i < 3; i++) tick();
        chk("o_still_l", 32'(core_chan), 32'd0);
        core_ack = 1'b1; core_dout = 16'h0A0A;
        tick();
        chk("o_chan_r", 32'(core_chan), 32'd1);
        chk("o_din_r", 32'(core_din), 32'h0202);
        core_dout = 16'h0B0B;
        tick();
        core_ack = 1'b0;
        chk("o_oval", 32'(out_valid), 32'd1);
        chk("o_left", 32'(left_out), 32'h0A0A);
        chk("o_right", 32'(right_out), 32'h0B0B);
        chk("o_req_done", 32'(core_req), 32'd0);
        chk("o_flag_held", 32'(overrun), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("o_clr", 32'(overrun), 32'd0);
        chk("o_dropped_idle", 32'(core_req), 32'd0);

        // Reset asserted mid-REQ_R
        valid = 1'b1; left_in = 16'h1111; right_in = 16'h2222;
        tick();
        valid = 1'b0;
        core_ack = 1'b1; core_dout = 16'h3333;
        tick();
        core_ack = 1'b0;
        chk("r_in_req_r", 32'(core_chan), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("r_req_async", 32'(core_req), 32'd0);
        chk("r_left_async", 32'(left_out), 32'd0);
        chk("r_right_async", 32'(right_out), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        valid = 1'b1; left_in = 16'h00FF; right_in = 16'hFF00;
        tick();
        valid = 1'b0;
        chk("r2_din_l", 32'(core_din), 32'h00FF);
        core_ack = 1'b1; core_dout = 16'hFF00;
        tick();
        core_dout = 16'h00FF;
        tick();
        core_ack = 1'b0;
        chk("r2_oval", 32'(out_valid), 32'd1);
        chk("r2_left", 32'(left_out), 32'hFF00);
        chk("r2_right", 32'(right_out), 32'h00FF);
        chk("r2_to_err", 32'(timeout_err), 32'd0);

`ifdef FX_WATCHDOG_EN
        // Watchdog: left never acked, expires with count 4 in REQ_L
        tick();
        valid = 1'b1; left_in = 16'h0F0F; right_in = 16'hF0F0;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("w_still_l", 32'(core_chan), 32'd0);
        chk("w_no_err_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("w_chan_r", 32'(core_chan), 32'd1);
        chk("w_err", 32'(timeout_err), 32'd1);
        core_ack = 1'b1; core_dout = 16'h1357;
        tick();
        core_ack = 1'b0;
        chk("w_oval", 32'(out_valid), 32'd1);
        chk("w_left_raw", 32'(left_out), 32'h0F0F);
        chk("w_right", 32'(right_out), 32'h1357);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
